// File: rtl/dumper_pkg.sv
// dumper_pkg: shared types and constants for the data memory dumper.
//   dump_state_t      FSM state encoding (IDLE, RUN, FLUSH)
//   DUMP_FIFO_DEPTH   number of words buffered between memory and sink
//   DATA_SIZE         default memory word width
//   DATA_MEMORY_SIZE  default number of data memory words
package dumper_pkg;

  localparam int DATA_SIZE        = 32;
  localparam int DATA_MEMORY_SIZE = 256;

  localparam int DUMP_FIFO_DEPTH  = 2;
  localparam int DUMP_PTR_WIDTH   = $clog2(DUMP_FIFO_DEPTH);
  localparam int DUMP_COUNT_WIDTH = $clog2(DUMP_FIFO_DEPTH + 1);

  localparam logic [DUMP_COUNT_WIDTH-1:0] DUMP_FIFO_FULL = DUMP_COUNT_WIDTH'(DUMP_FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } dump_state_t;

endpackage

// File: rtl/dump_fifo.sv
// dump_fifo: small FIFO holding {data, address, last} words returned from
// memory until the sink accepts them. The head entry is presented directly.
// Ports:
//   clock, reset               clock and asynchronous active-low reset
//   push, push_data,
//   push_address, push_last    write side
//   pop                        remove head entry (ignored when empty)
//   head_data, head_address,
//   head_last                  current head entry (zero when reset)
//   count                      number of stored entries
module dump_fifo
  import dumper_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_SIZE,
  parameter int ADDR_WIDTH = $clog2(DATA_MEMORY_SIZE)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        push,
  input  logic [DATA_WIDTH-1:0]       push_data,
  input  logic [ADDR_WIDTH-1:0]       push_address,
  input  logic                        push_last,
  input  logic                        pop,
  output logic [DATA_WIDTH-1:0]       head_data,
  output logic [ADDR_WIDTH-1:0]       head_address,
  output logic                        head_last,
  output logic [DUMP_COUNT_WIDTH-1:0] count
);

  localparam logic [DUMP_PTR_WIDTH-1:0]   PTR_ONE   = DUMP_PTR_WIDTH'(1);
  localparam logic [DUMP_COUNT_WIDTH-1:0] COUNT_ONE = DUMP_COUNT_WIDTH'(1);

  logic [DATA_WIDTH-1:0]     data_mem [DUMP_FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]     addr_mem [DUMP_FIFO_DEPTH];
  logic                      last_mem [DUMP_FIFO_DEPTH];
  logic [DUMP_PTR_WIDTH-1:0] rd_ptr;
  logic [DUMP_PTR_WIDTH-1:0] wr_ptr;
  logic                      do_pop;
  logic                      do_push;

  // A push into a full FIFO is only accepted if the head leaves in the same cycle.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != DUMP_FIFO_FULL) || do_pop);

  assign head_data    = data_mem[rd_ptr];
  assign head_address = addr_mem[rd_ptr];
  assign head_last    = last_mem[rd_ptr];

  // Storage is cleared on reset so the head outputs read as zero immediately.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DUMP_FIFO_DEPTH; i++) begin
        data_mem[i] <= '0;
        addr_mem[i] <= '0;
        last_mem[i] <= 1'b0;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        data_mem[wr_ptr] <= push_data;
        addr_mem[wr_ptr] <= push_address;
        last_mem[wr_ptr] <= push_last;
        wr_ptr           <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + COUNT_ONE;
        2'b01:   count <= count - COUNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/data_memory_dumper.sv
// data_memory_dumper: streams a contiguous, optionally wrapping, range of data
// memory out over a valid/ready interface, one word per accepted transfer.
// Optional feature: define DUMP_CHECKSUM_EN to add the `checksum` output
// (sum of all transferred words, cleared at start).
// Ports:
//   clock, reset          clock and asynchronous active-low reset
//   start                 begin a dump (sampled only while idle)
//   first_addr, last_addr inclusive address range, latched on start
//   busy, done            dump in progress / one-cycle completion pulse
//   mem_read_enable,
//   mem_address, mem_data memory read port (data one cycle after strobe)
//   out_valid, out_ready,
//   out_data, out_address,
//   out_last              output stream; out_last marks the final word
//   checksum              (DUMP_CHECKSUM_EN only) running sum of sent words
module data_memory_dumper
  import dumper_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_SIZE,
  parameter int ADDR_WIDTH = $clog2(DATA_MEMORY_SIZE)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] first_addr,
  input  logic [ADDR_WIDTH-1:0] last_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_read_enable,
  output logic [ADDR_WIDTH-1:0] mem_address,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_address,
  output logic                  out_last
`ifdef DUMP_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] checksum
`endif
);

  localparam logic [ADDR_WIDTH-1:0]     ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]       COUNT_ONE = (ADDR_WIDTH + 1)'(1);
  localparam logic [DUMP_COUNT_WIDTH:0] OCC_LIMIT = (DUMP_COUNT_WIDTH + 1)'(DUMP_FIFO_DEPTH);

  dump_state_t                 state;
  logic [ADDR_WIDTH-1:0]       read_addr;
  logic [ADDR_WIDTH:0]         reads_left;
  logic                        inflight;
  logic                        inflight_last;
  logic [ADDR_WIDTH-1:0]       inflight_addr;
  logic [DUMP_COUNT_WIDTH-1:0] fifo_count;
  logic [DUMP_COUNT_WIDTH:0]   occupancy;
  logic                        pop;
  logic                        issue;

  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid && out_ready;

  // Words already committed to the FIFO once this cycle's transfer (if any)
  // leaves. Counting the departing word is what lets a 2-entry FIFO sustain
  // one word per cycle against a two-cycle read round trip.
  assign occupancy = {1'b0, fifo_count}
                   + {{DUMP_COUNT_WIDTH{1'b0}}, inflight}
                   - {{DUMP_COUNT_WIDTH{1'b0}}, pop};

  assign issue           = (state == RUN) && (reads_left != '0) && (occupancy < OCC_LIMIT);
  assign mem_read_enable = issue;
  assign mem_address     = read_addr;

  // Control FSM. The read address and remaining count advance with each
  // issued read; the last read moves to FLUSH, and the hand-off of the word
  // tagged last ends the dump.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      read_addr     <= '0;
      reads_left    <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      inflight_addr <= '0;
    end else begin
      done          <= 1'b0;
      inflight      <= issue;
      inflight_last <= issue && (reads_left == COUNT_ONE);
      inflight_addr <= read_addr;
      case (state)
        IDLE: begin
          if (start) begin
            read_addr  <= first_addr;
            // Subtraction stays ADDR_WIDTH wide so a wrapping range counts correctly.
            reads_left <= {1'b0, last_addr - first_addr} + COUNT_ONE;
            busy       <= 1'b1;
            state      <= RUN;
          end
        end
        RUN: begin
          if (issue) begin
            read_addr  <= read_addr + ADDR_ONE;
            reads_left <= reads_left - COUNT_ONE;
            if (reads_left == COUNT_ONE) begin
              state <= FLUSH;
            end
          end
        end
        FLUSH: begin
          if (pop && out_last) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  dump_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_fifo (
    .clock        (clock),
    .reset        (reset),
    .push         (inflight),
    .push_data    (mem_data),
    .push_address (inflight_addr),
    .push_last    (inflight_last),
    .pop          (pop),
    .head_data    (out_data),
    .head_address (out_address),
    .head_last    (out_last),
    .count        (fifo_count)
  );

`ifdef DUMP_CHECKSUM_EN
  // Running sum of accepted words; holds while idle so it can be read after done.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      checksum <= '0;
    end else if ((state == IDLE) && start) begin
      checksum <= '0;
    end else if (pop) begin
      checksum <= checksum + out_data;
    end
  end
`endif

endmodule

// File: tb/tb_data_memory_dumper.sv
// tb_data_memory_dumper: self-checking bench for data_memory_dumper.
// A synchronous memory model answers reads; each dump's expected word list is
// built from the address range and memory contents and compared against the
// words actually handed off. Define DUMP_CHECKSUM_EN to also check checksum.
module tb_data_memory_dumper;

  localparam int AW        = 8;
  localparam int DW        = 32;
  localparam int MEM_WORDS = 256;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] first_addr = '0;
  logic [AW-1:0] last_addr = '0;
  logic          busy;
  logic          done;
  logic          mem_read_enable;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_address;
  logic          out_last;
`ifdef DUMP_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  logic [DW-1:0] mem [MEM_WORDS];

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_data [$];
  logic [AW-1:0] exp_addr [$];
  logic          exp_last [$];
  logic [DW-1:0] exp_sum;

  logic [DW-1:0] obs_data [$];
  logic [AW-1:0] obs_addr [$];
  logic          obs_last [$];
  int            obs_cycle [$];
  int            first_valid_cycle;
  int            done_cycle;
  int            done_count;
  int            busy_bad;
  int            stable_bad;
  int            max_outstanding;
  int            issued_total;
  bit            timed_out;

  data_memory_dumper #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .first_addr      (first_addr),
    .last_addr       (last_addr),
    .busy            (busy),
    .done            (done),
    .mem_read_enable (mem_read_enable),
    .mem_address     (mem_address),
    .mem_data        (mem_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .out_address     (out_address),
    .out_last        (out_last)
`ifdef DUMP_CHECKSUM_EN
    ,
    .checksum        (checksum)
`endif
  );

  always #5 clock = ~clock;

  // Memory returns the addressed word the cycle after the strobe.
  always @(posedge clock) begin
    if (mem_read_enable) mem_data <= mem[mem_address];
  end

  function automatic logic [52:0] outputs_snapshot();
    return {busy, done, mem_read_enable, mem_address, out_valid, out_data, out_address, out_last};
  endfunction

  // Runs one dump and records what the DUT does; expected words come from the
  // range rule: n = ((l - f) mod 256) + 1 words starting at f, wrapping at 256.
  task automatic run_dump(input logic [AW-1:0] f, input logic [AW-1:0] l,
                          input int ready_mode, input int restart_at, input int budget);
    int            n;
    int            k;
    bit            prev_stall;
    logic [DW-1:0] prev_data;
    logic [AW-1:0] prev_addr;
    logic          prev_last;
    n = int'(l - f) + 1;
    exp_data.delete(); exp_addr.delete(); exp_last.delete();
    exp_sum = '0;
    for (int i = 0; i < n; i++) begin
      logic [AW-1:0] a;
      a = AW'((int'(f) + i) % MEM_WORDS);
      exp_addr.push_back(a);
      exp_data.push_back(mem[a]);
      exp_last.push_back(i == n - 1);
      exp_sum = exp_sum + mem[a];
    end
    obs_data.delete(); obs_addr.delete(); obs_last.delete(); obs_cycle.delete();
    first_valid_cycle = -1; done_cycle = -1; done_count = 0; busy_bad = 0;
    stable_bad = 0; max_outstanding = 0; issued_total = 0; timed_out = 0;
    prev_stall = 0; prev_data = '0; prev_addr = '0; prev_last = 0;
    @(posedge clock); #1;
    first_addr = f; last_addr = l; start = 1'b1; out_ready = 1'b0;
    @(posedge clock);
    k = 0;
    while (1'b1) begin
      #1;
      start = (k == restart_at);
      if (start) begin
        first_addr = f + 8'd37;
        last_addr  = f + 8'd5;
      end
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (k % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clock);
      if (prev_stall && (out_valid !== 1'b1 || out_data !== prev_data ||
                         out_address !== prev_addr || out_last !== prev_last))
        stable_bad++;
      if (out_valid === 1'b1 && first_valid_cycle < 0) first_valid_cycle = k;
      if (mem_read_enable === 1'b1) issued_total++;
      if (out_valid === 1'b1 && out_ready) begin
        obs_data.push_back(out_data);
        obs_addr.push_back(out_address);
        obs_last.push_back(out_last);
        obs_cycle.push_back(k);
      end
      if (issued_total - obs_data.size() > max_outstanding)
        max_outstanding = issued_total - obs_data.size();
      if (done === 1'b1) begin
        done_count++;
        if (done_cycle < 0) done_cycle = k;
      end
      if (busy !== ((done_cycle < 0) ? 1'b1 : 1'b0)) busy_bad++;
      prev_stall = (out_valid === 1'b1) && !out_ready;
      prev_data  = out_data;
      prev_addr  = out_address;
      prev_last  = out_last;
      if (done_cycle >= 0 && k > done_cycle) break;
      if (k >= budget) begin
        timed_out = 1;
        break;
      end
      k++;
      @(posedge clock);
    end
    start = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (outputs_snapshot() !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h, want 0", outputs_snapshot());
    end
`ifdef DUMP_CHECKSUM_EN
    checks++;
    if (checksum !== '0) begin
      errors++;
      $display("[TB] FAIL reset_checksum: got %h, want 0", checksum);
    end
`endif
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (outputs_snapshot() !== '0) begin
      errors++;
      $display("[TB] FAIL idle_outputs: got %h, want 0", outputs_snapshot());
    end
  endtask

  task automatic test_directed();
    mem[8'h1C] = 32'h5318_0008;
    mem[8'h1D] = 32'hDEAD_BEEF;
    mem[8'h1E] = 32'hFFFF_FFF3;
    run_dump(8'h1C, 8'h1E, 0, -1, 40);
    checks++;
    if (obs_data.size() != exp_data.size() || timed_out) begin
      errors++;
      $display("[TB] FAIL directed_count: got %0d words (timeout %0b), want %0d", obs_data.size(), timed_out, exp_data.size());
    end
    for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
      checks++;
      if ({obs_addr[i], obs_data[i], obs_last[i], 32'(obs_cycle[i])} !== {exp_addr[i], exp_data[i], exp_last[i], 32'(i + 2)}) begin
        errors++;
        $display("[TB] FAIL directed_word%0d: got addr %h data %h last %b cycle %0d, want addr %h data %h last %b cycle %0d",
                 i, obs_addr[i], obs_data[i], obs_last[i], obs_cycle[i], exp_addr[i], exp_data[i], exp_last[i], i + 2);
      end
    end
    checks++;
    if (done_cycle != 5 || done_count != 1 || busy_bad != 0) begin
      errors++;
      $display("[TB] FAIL directed_done: got done cycle %0d count %0d busy errors %0d, want 5 1 0", done_cycle, done_count, busy_bad);
    end
`ifdef DUMP_CHECKSUM_EN
    checks++;
    if (checksum !== exp_sum) begin
      errors++;
      $display("[TB] FAIL directed_checksum: got %h, want %h", checksum, exp_sum);
    end
`endif
  endtask

  task automatic test_single_word();
    mem[8'h30] = 32'hDEAD_BEEF;
    run_dump(8'h30, 8'h30, 0, -1, 40);
    checks++;
    if (obs_data.size() != 1 || timed_out) begin
      errors++;
      $display("[TB] FAIL single_count: got %0d words (timeout %0b), want 1", obs_data.size(), timed_out);
    end else if ({obs_addr[0], obs_data[0], obs_last[0]} !== {8'h30, 32'hDEAD_BEEF, 1'b1}) begin
      errors++;
      $display("[TB] FAIL single_word: got addr %h data %h last %b, want addr 30 data deadbeef last 1", obs_addr[0], obs_data[0], obs_last[0]);
    end
    checks++;
    if (first_valid_cycle != 2 || done_cycle != 3) begin
      errors++;
      $display("[TB] FAIL single_timing: got first valid %0d done %0d, want 2 3", first_valid_cycle, done_cycle);
    end
  endtask

  task automatic test_wrap();
    run_dump(8'hFE, 8'h01, 2, -1, 100);
    checks++;
    if (obs_data.size() != 4 || timed_out) begin
      errors++;
      $display("[TB] FAIL wrap_count: got %0d words (timeout %0b), want 4", obs_data.size(), timed_out);
    end
    for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
      checks++;
      if ({obs_addr[i], obs_data[i], obs_last[i]} !== {exp_addr[i], exp_data[i], exp_last[i]}) begin
        errors++;
        $display("[TB] FAIL wrap_word%0d: got addr %h data %h last %b, want addr %h data %h last %b",
                 i, obs_addr[i], obs_data[i], obs_last[i], exp_addr[i], exp_data[i], exp_last[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [AW-1:0] f;
    f = AW'($urandom);
    run_dump(f, f + 8'd15, 1, -1, 200);
    checks++;
    if (obs_data.size() != 16 || timed_out || issued_total != 16) begin
      errors++;
      $display("[TB] FAIL bp_count: got %0d words %0d reads (timeout %0b), want 16 16", obs_data.size(), issued_total, timed_out);
    end
    for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
      checks++;
      if ({obs_addr[i], obs_data[i], obs_last[i]} !== {exp_addr[i], exp_data[i], exp_last[i]}) begin
        errors++;
        $display("[TB] FAIL bp_word%0d: got addr %h data %h last %b, want addr %h data %h last %b",
                 i, obs_addr[i], obs_data[i], obs_last[i], exp_addr[i], exp_data[i], exp_last[i]);
      end
    end
    checks++;
    if (stable_bad != 0 || max_outstanding > 2) begin
      errors++;
      $display("[TB] FAIL bp_stall: got %0d unstable cycles, max outstanding %0d, want 0 and at most 2", stable_bad, max_outstanding);
    end
  endtask

  task automatic test_restart_ignored();
    logic [AW-1:0] f;
    f = AW'($urandom);
    run_dump(f, f + 8'd20, 0, 5, 100);
    checks++;
    if (obs_data.size() != 21 || timed_out || done_cycle != 23) begin
      errors++;
      $display("[TB] FAIL restart_count: got %0d words done %0d (timeout %0b), want 21 words done 23", obs_data.size(), done_cycle, timed_out);
    end
    for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
      checks++;
      if ({obs_addr[i], obs_data[i], obs_last[i]} !== {exp_addr[i], exp_data[i], exp_last[i]}) begin
        errors++;
        $display("[TB] FAIL restart_word%0d: got addr %h data %h last %b, want addr %h data %h last %b",
                 i, obs_addr[i], obs_data[i], obs_last[i], exp_addr[i], exp_data[i], exp_last[i]);
      end
    end
  endtask

  task automatic test_reset_mid_dump();
    logic [AW-1:0] f;
    logic [AW-1:0] g;
    f = AW'($urandom);
    g = f + 8'd100;
    @(posedge clock); #1;
    first_addr = f; last_addr = f + 8'd10; start = 1'b1; out_ready = 1'b0;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (out_valid !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midreset_pre: got valid %b busy %b, want 1 1", out_valid, busy);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (outputs_snapshot() !== '0) begin
      errors++;
      $display("[TB] FAIL midreset_outputs: got %h, want 0", outputs_snapshot());
    end
`ifdef DUMP_CHECKSUM_EN
    checks++;
    if (checksum !== '0) begin
      errors++;
      $display("[TB] FAIL midreset_checksum: got %h, want 0", checksum);
    end
`endif
    @(posedge clock); #1;
    reset = 1'b1;
    run_dump(g, g + 8'd6, 2, -1, 100);
    checks++;
    if (obs_data.size() != 7 || timed_out) begin
      errors++;
      $display("[TB] FAIL midreset_count: got %0d words (timeout %0b), want 7", obs_data.size(), timed_out);
    end
    for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
      checks++;
      if ({obs_addr[i], obs_data[i], obs_last[i]} !== {exp_addr[i], exp_data[i], exp_last[i]}) begin
        errors++;
        $display("[TB] FAIL midreset_word%0d: got addr %h data %h last %b, want addr %h data %h last %b",
                 i, obs_addr[i], obs_data[i], obs_last[i], exp_addr[i], exp_data[i], exp_last[i]);
      end
    end
  endtask

  task automatic test_full_range();
    logic [AW-1:0] f;
    int            bad;
    f = AW'($urandom);
    run_dump(f, f - 8'd1, 2, -1, 2000);
    checks++;
    if (obs_data.size() != MEM_WORDS || timed_out) begin
      errors++;
      $display("[TB] FAIL full_count: got %0d words (timeout %0b), want %0d", obs_data.size(), timed_out, MEM_WORDS);
    end
    bad = 0;
    for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
      if ({obs_addr[i], obs_data[i], obs_last[i]} !== {exp_addr[i], exp_data[i], exp_last[i]}) bad++;
    end
    checks++;
    if (bad != 0 || stable_bad != 0) begin
      errors++;
      $display("[TB] FAIL full_words: got %0d wrong words %0d unstable cycles, want 0 0", bad, stable_bad);
    end
`ifdef DUMP_CHECKSUM_EN
    checks++;
    if (checksum !== exp_sum) begin
      errors++;
      $display("[TB] FAIL full_checksum: got %h, want %h", checksum, exp_sum);
    end
`endif
  endtask

  task automatic test_random_dumps();
    for (int t = 0; t < 4; t++) begin
      logic [AW-1:0] f;
      int            bad;
      f = AW'($urandom);
      run_dump(f, f + AW'($urandom_range(0, 24)), 2, -1, 200);
      bad = 0;
      for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
        if ({obs_addr[i], obs_data[i], obs_last[i]} !== {exp_addr[i], exp_data[i], exp_last[i]}) bad++;
      end
      checks++;
      if (obs_data.size() != exp_data.size() || bad != 0 || timed_out || done_count != 1 || busy_bad != 0 || max_outstanding > 2) begin
        errors++;
        $display("[TB] FAIL random%0d: got %0d words %0d wrong done %0d busy errors %0d outstanding %0d, want %0d words 0 wrong done 1 busy errors 0 outstanding at most 2",
                 t, obs_data.size(), bad, done_count, busy_bad, max_outstanding, exp_data.size());
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;
    test_reset();
    test_directed();
    test_single_word();
    test_wrap();
    test_backpressure();
    test_restart_ignored();
    test_reset_mid_dump();
    test_full_range();
    test_random_dumps();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
